// File: rtl/diff_freq_serial_in.sv
// ---------------------------------------------------------------------------
// diff_freq_serial_in
//
// Receive side of the variable-rate serial link. Rebuilds a DATA_BIT-wide
// word sent LSB first. Each bit lasts LOW_FREQ or HIGH_FREQ clocks, chosen by
// i_sel_freq. The select is driven exactly as it is for the transmitter. Every
// bit is resolved by a 3-sample majority vote taken around mid-bit.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   i_sel_freq   period select for the next bit (1 = HIGH_FREQ, 0 = LOW_FREQ)
//   i_start      begin receiving one word (ignored while busy)
//   i_stop       abort the current word (ignored while idle)
//   i_repeat     go straight into another word after the current one completes
//   i_data       serial line, already synchronous to clk
//   o_data       last completed word
//   o_done_tick  one-clock pulse when o_data updates
//   o_busy       high while aligning, receiving or finishing a word
//   o_vote_err   some bit of the last word had disagreeing samples
// ---------------------------------------------------------------------------
module diff_freq_serial_in #(
    parameter int DATA_BIT  = 16,
    parameter int LOW_FREQ  = 20,
    parameter int HIGH_FREQ = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_sel_freq,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_repeat,
    input  logic                i_data,
    output logic [DATA_BIT-1:0] o_data,
    output logic                o_done_tick,
    output logic                o_busy,
    output logic                o_vote_err
);

    localparam logic [7:0] LOW_MAX  = 8'(LOW_FREQ - 1);
    localparam logic [7:0] HIGH_MAX = 8'(HIGH_FREQ - 1);
    localparam logic [5:0] LAST_IDX = 6'(DATA_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ALIGN,
        S_RECV,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [7:0]          count_q;
    logic [7:0]          count_max_q;
    logic [5:0]          bit_idx_q;
    logic [DATA_BIT-1:0] shift_q;
    logic [1:0]          vote_q;
    logic                err_acc_q;
    logic [DATA_BIT-1:0] data_q;
    logic                done_tick_q;
    logic                busy_q;
    logic                vote_err_q;

    logic [7:0]          sel_max_d;
    logic [7:0]          mid_d;
    logic [1:0]          ones_d;
    logic                bit_d;
    logic                mismatch_d;
    logic [DATA_BIT-1:0] shift_d;

    // The vote total includes the third sample, which is taken in the same
    // cycle the bit is resolved. With at most three ones, "ones >= 2" is
    // simply the upper bit of the 2-bit count.
    always_comb begin
        sel_max_d  = i_sel_freq ? HIGH_MAX : LOW_MAX;
        mid_d      = count_max_q >> 1;
        ones_d     = vote_q + {1'b0, i_data};
        bit_d      = ones_d[1];
        mismatch_d = (ones_d != 2'd0) && (ones_d != 2'd3);
        // Shift right with the new bit entering at the MSB, so bit 0 ends at [0].
        shift_d    = (shift_q >> 1) | (DATA_BIT'(bit_d) << (DATA_BIT - 1));
    end

    // Single-process FSM. i_stop is checked first in every busy state, so an
    // abort overrides bit completion, done and repeat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            count_max_q <= LOW_MAX;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            vote_q      <= '0;
            err_acc_q   <= 1'b0;
            data_q      <= '0;
            done_tick_q <= 1'b0;
            busy_q      <= 1'b0;
            vote_err_q  <= 1'b0;
        end else begin
            done_tick_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        count_max_q <= sel_max_d;
                        count_q     <= '0;
                        bit_idx_q   <= '0;
                        err_acc_q   <= 1'b0;
                        shift_q     <= '0;
                        vote_q      <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= S_ALIGN;
                    end
                end
                // One idle cycle that matches the transmitter's start-to-line delay.
                S_ALIGN: begin
                    if (i_stop) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        count_q <= '0;
                        state_q <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (i_stop) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        if (count_q == mid_d - 8'd1) begin
                            vote_q <= {1'b0, i_data};
                        end else if (count_q == mid_d) begin
                            vote_q <= ones_d;
                        end
                        if (count_q == mid_d + 8'd1) begin
                            shift_q <= shift_d;
                            if (mismatch_d) begin
                                err_acc_q <= 1'b1;
                            end
                        end
                        // The period of the next bit is taken at this bit boundary.
                        if (count_q == count_max_q) begin
                            count_q     <= '0;
                            count_max_q <= sel_max_d;
                            if (bit_idx_q == LAST_IDX) begin
                                state_q <= S_DONE;
                            end else begin
                                bit_idx_q <= bit_idx_q + 6'd1;
                            end
                        end else begin
                            count_q <= count_q + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (i_stop) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        data_q      <= shift_q;
                        vote_err_q  <= err_acc_q;
                        done_tick_q <= 1'b1;
                        if (i_repeat) begin
                            bit_idx_q   <= '0;
                            err_acc_q   <= 1'b0;
                            count_q     <= '0;
                            count_max_q <= sel_max_d;
                            state_q     <= S_ALIGN;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_data      = data_q;
    assign o_done_tick = done_tick_q;
    assign o_busy      = busy_q;
    assign o_vote_err  = vote_err_q;

endmodule

// File: tb/tb_diff_freq_serial_in.sv
// ---------------------------------------------------------------------------
// tb_diff_freq_serial_in
//
// Drives serial words the way the transmitter would. Expected words, vote
// flags and done-tick cycles go into a queue. A monitor collects what the
// receiver actually reports, and each scenario task compares the two.
// ---------------------------------------------------------------------------
module tb_diff_freq_serial_in;

    localparam int DW   = 16;
    localparam int LOW  = 20;
    localparam int HIGH = 10;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          cyc;
    } entry_t;

    logic          clk;
    logic          rst_n;
    logic          i_sel_freq;
    logic          i_start;
    logic          i_stop;
    logic          i_repeat;
    logic          i_data;
    logic [DW-1:0] o_data;
    logic          o_done_tick;
    logic          o_busy;
    logic          o_vote_err;

    int     cyc = 0;
    int     tickCount = 0;
    int     passCount = 0;
    int     checkCount = 0;
    entry_t expQ[$];
    entry_t obsQ[$];

    diff_freq_serial_in #(
        .DATA_BIT (DW),
        .LOW_FREQ (LOW),
        .HIGH_FREQ(HIGH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_sel_freq (i_sel_freq),
        .i_start    (i_start),
        .i_stop     (i_stop),
        .i_repeat   (i_repeat),
        .i_data     (i_data),
        .o_data     (o_data),
        .o_done_tick(o_done_tick),
        .o_busy     (o_busy),
        .o_vote_err (o_vote_err)
    );

    // Free-running clock and a cycle counter used to timestamp done ticks.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every reported word, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n && o_done_tick === 1'b1) begin
            obsQ.push_back('{o_data, o_vote_err, cyc});
            tickCount++;
        end
    end

    // Raise i_start for one cycle. Return at the first receive cycle,
    // with k set to the cycle number of the start cycle.
    task automatic startWord(input logic sel0, output int k);
        @(posedge clk); #1;
        i_start    = 1'b1;
        i_sel_freq = sel0;
        i_data     = 1'b0;
        k          = cyc;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(posedge clk); #1;
    endtask

    // Drive nBits bits, LSB first. During bit b the select already shows the
    // period of bit b+1, because the receiver reloads it at the bit boundary.
    // An optional one-cycle glitch lands on the mid sample of glitchBit.
    task automatic applyStimulus(input logic [15:0] word, input logic [15:0] selMask,
                                 input int glitchBit, input logic nextSel, input int nBits);
        for (int b = 0; b < nBits; b++) begin
            int p;
            int m;
            p = selMask[b] ? HIGH : LOW;
            m = (p - 1) >> 1;
            if (b < 15) i_sel_freq = selMask[b+1];
            else        i_sel_freq = nextSel;
            for (int c = 0; c < p; c++) begin
                i_data = word[b] ^ ((b == glitchBit) && (c == m));
                @(posedge clk); #1;
            end
        end
        i_data = 1'b0;
    endtask

    function automatic int wordCycles(input logic [15:0] selMask);
        int t;
        t = 0;
        for (int b = 0; b < 16; b++) t += selMask[b] ? HIGH : LOW;
        return t;
    endfunction

    // Wait, within a cycle budget, for one observed word. Then pop it
    // together with the matching expected entry.
    task automatic popPair(input int budget, output entry_t e, output entry_t o, output bit ok);
        int n;
        n = 0;
        while (obsQ.size() == 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        ok = (obsQ.size() > 0) && (expQ.size() > 0);
        if (ok) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
        end
    endtask

    // Send a full word and stop in the cycle right after S_DONE.
    task automatic runWord(input logic [15:0] word, input logic [15:0] selMask,
                           input int glitchBit);
        int k;
        startWord(selMask[0], k);
        expQ.push_back('{word, glitchBit >= 0, k + 2 + wordCycles(selMask) + 1});
        applyStimulus(word, selMask, glitchBit, 1'b0, 16);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checkCount++;
        if (o_data !== 16'h0000) $display("[TB] FAIL reset_data: got %h expected 0000", o_data);
        else passCount++;
        checkCount++;
        if (o_done_tick !== 1'b0) $display("[TB] FAIL reset_tick: got %b expected 0", o_done_tick);
        else passCount++;
        checkCount++;
        if (o_busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", o_busy);
        else passCount++;
        checkCount++;
        if (o_vote_err !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", o_vote_err);
        else passCount++;
    endtask

    task automatic test_low_word();
        entry_t e, o;
        bit ok;
        int t0;
        t0 = tickCount;
        runWord(16'hA5C3, 16'h0000, -1);
        checkCount++;
        if (o_busy !== 1'b0) $display("[TB] FAIL low_busy_after: got %b expected 0", o_busy);
        else passCount++;
        popPair(10, e, o, ok);
        checkCount++;
        if (!ok) begin
            $display("[TB] FAIL low_no_done: got no done tick, expected one");
        end else begin
            passCount++;
            checkCount++;
            if (o.data !== e.data) $display("[TB] FAIL low_data: got %h expected %h", o.data, e.data);
            else passCount++;
            checkCount++;
            if (o.err !== e.err) $display("[TB] FAIL low_err: got %b expected %b", o.err, e.err);
            else passCount++;
            checkCount++;
            if (o.cyc !== e.cyc) $display("[TB] FAIL low_latency: got cycle %0d expected %0d", o.cyc, e.cyc);
            else passCount++;
        end
        repeat (5) @(posedge clk);
        #1;
        checkCount++;
        if (tickCount - t0 !== 1) $display("[TB] FAIL low_tick_count: got %0d expected 1", tickCount - t0);
        else passCount++;
    endtask

    task automatic test_mixed_sel();
        entry_t e, o;
        bit ok;
        runWord(16'h00FF, 16'h00FF, -1);
        popPair(10, e, o, ok);
        checkCount++;
        if (!ok) begin
            $display("[TB] FAIL mixed_no_done: got no done tick, expected one");
        end else begin
            passCount++;
            checkCount++;
            if (o.data !== e.data) $display("[TB] FAIL mixed_data: got %h expected %h", o.data, e.data);
            else passCount++;
            checkCount++;
            if (o.cyc !== e.cyc) $display("[TB] FAIL mixed_latency: got cycle %0d expected %0d", o.cyc, e.cyc);
            else passCount++;
        end
    endtask

    task automatic test_vote_glitch();
        entry_t e, o;
        bit ok;
        runWord(16'h1234, 16'h0000, 3);
        popPair(10, e, o, ok);
        checkCount++;
        if (!ok) begin
            $display("[TB] FAIL glitch_no_done: got no done tick, expected one");
        end else begin
            passCount++;
            checkCount++;
            if (o.data !== e.data) $display("[TB] FAIL glitch_data: got %h expected %h", o.data, e.data);
            else passCount++;
            checkCount++;
            if (o.err !== 1'b1) $display("[TB] FAIL glitch_err: got %b expected 1", o.err);
            else passCount++;
        end
        runWord(16'h5A5A, 16'h0000, -1);
        popPair(10, e, o, ok);
        checkCount++;
        if (!ok) begin
            $display("[TB] FAIL clean_no_done: got no done tick, expected one");
        end else begin
            passCount++;
            checkCount++;
            if (o.err !== 1'b0) $display("[TB] FAIL clean_err: got %b expected 0", o.err);
            else passCount++;
            checkCount++;
            if (o.data !== e.data) $display("[TB] FAIL clean_data: got %h expected %h", o.data, e.data);
            else passCount++;
        end
    endtask

    task automatic test_back_to_back();
        entry_t e1, o1, e2, o2;
        bit ok1, ok2;
        int k;
        startWord(1'b0, k);
        expQ.push_back('{16'h1111, 1'b0, k + 2 + 320 + 1});
        applyStimulus(16'h1111, 16'h0000, -1, 1'b0, 16);
        i_repeat = 1'b1;
        @(posedge clk); #1;
        i_repeat = 1'b0;
        @(posedge clk); #1;
        expQ.push_back('{16'h2222, 1'b0, k + 2 + 320 + 1 + 322});
        applyStimulus(16'h2222, 16'h0000, -1, 1'b0, 16);
        @(posedge clk); #1;
        checkCount++;
        if (o_busy !== 1'b0) $display("[TB] FAIL repeat_idle: got busy %b expected 0", o_busy);
        else passCount++;
        popPair(10, e1, o1, ok1);
        popPair(10, e2, o2, ok2);
        checkCount++;
        if (!(ok1 && ok2)) begin
            $display("[TB] FAIL repeat_done_count: got %0d ticks expected 2", ok1 + ok2);
        end else begin
            passCount++;
            checkCount++;
            if (o1.data !== e1.data) $display("[TB] FAIL repeat_data1: got %h expected %h", o1.data, e1.data);
            else passCount++;
            checkCount++;
            if (o2.data !== e2.data) $display("[TB] FAIL repeat_data2: got %h expected %h", o2.data, e2.data);
            else passCount++;
            checkCount++;
            if (o1.cyc !== e1.cyc) $display("[TB] FAIL repeat_latency1: got cycle %0d expected %0d", o1.cyc, e1.cyc);
            else passCount++;
            checkCount++;
            if (o2.cyc - o1.cyc !== 322) $display("[TB] FAIL repeat_spacing: got %0d expected 322", o2.cyc - o1.cyc);
            else passCount++;
        end
    endtask

    task automatic test_stop();
        entry_t e, o;
        bit ok;
        int k;
        int t0;
        runWord(16'h0F0F, 16'h0000, -1);
        popPair(10, e, o, ok);
        checkCount++;
        if (!ok || o.data !== 16'h0F0F) $display("[TB] FAIL stop_prior_word: got %h expected 0f0f", o.data);
        else passCount++;
        t0 = tickCount;
        startWord(1'b0, k);
        applyStimulus(16'hFFFF, 16'h0000, -1, 1'b0, 7);
        i_data = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        i_stop = 1'b1;
        @(posedge clk); #1;
        i_stop = 1'b0;
        i_data = 1'b0;
        checkCount++;
        if (o_busy !== 1'b0) $display("[TB] FAIL stop_idle: got busy %b expected 0", o_busy);
        else passCount++;
        repeat (400) @(posedge clk);
        #1;
        checkCount++;
        if (tickCount !== t0) $display("[TB] FAIL stop_no_tick: got %0d ticks expected 0", tickCount - t0);
        else passCount++;
        checkCount++;
        if (o_data !== 16'h0F0F) $display("[TB] FAIL stop_data_hold: got %h expected 0f0f", o_data);
        else passCount++;
    endtask

    task automatic test_async_reset();
        entry_t e, o;
        bit ok;
        int k;
        startWord(1'b0, k);
        applyStimulus(16'h5555, 16'h0000, -1, 1'b0, 3);
        rst_n = 1'b0;
        #1;
        checkCount++;
        if (o_data !== 16'h0000) $display("[TB] FAIL areset_data: got %h expected 0000", o_data);
        else passCount++;
        checkCount++;
        if (o_busy !== 1'b0) $display("[TB] FAIL areset_busy: got %b expected 0", o_busy);
        else passCount++;
        checkCount++;
        if (o_vote_err !== 1'b0 || o_done_tick !== 1'b0)
            $display("[TB] FAIL areset_flags: got err %b tick %b expected 0 0", o_vote_err, o_done_tick);
        else passCount++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        runWord(16'hBEEF, 16'h0000, -1);
        popPair(10, e, o, ok);
        checkCount++;
        if (!ok) begin
            $display("[TB] FAIL beef_no_done: got no done tick, expected one");
        end else begin
            passCount++;
            checkCount++;
            if (o.data !== e.data) $display("[TB] FAIL beef_data: got %h expected %h", o.data, e.data);
            else passCount++;
            checkCount++;
            if (o.cyc !== e.cyc) $display("[TB] FAIL beef_latency: got cycle %0d expected %0d", o.cyc, e.cyc);
            else passCount++;
        end
    endtask

    // Safety net so the run always ends by itself.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got no finish expected finish before 2ms");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n      = 1'b0;
        i_sel_freq = 1'b0;
        i_start    = 1'b0;
        i_stop     = 1'b0;
        i_repeat   = 1'b0;
        i_data     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        test_reset();
        test_low_word();
        test_mixed_sel();
        test_vote_glitch();
        test_back_to_back();
        test_stop();
        test_async_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/diff_freq_serial_in.md
Name: diff_freq_serial_in

Overview:
- Receive-side counterpart of the variable-rate serial transmitter: reconstructs a DATA_BIT-wide word sent LSB first, where each bit lasts LOW_FREQ or HIGH_FREQ clocks.
- Per-bit period follows i_sel_freq, which the system drives identically to the transmitter's select.
- Each bit is resolved by a 3-sample majority vote around mid-bit.
- Sits on the loopback/test path, or at the far end of a same-clock serial link.

Parameters:
- DATA_BIT, 16: word width; legal range 1..63.
- LOW_FREQ, 20: clocks per bit when i_sel_freq=0; 8-bit value, minimum 3.
- HIGH_FREQ, 10: clocks per bit when i_sel_freq=1; 8-bit value, minimum 3.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- i_sel_freq  input  1  period select for the next bit (1=HIGH_FREQ, 0=LOW_FREQ).
- i_start  input  1  begin receiving one word.
- i_stop  input  1  abort reception.
- i_repeat  input  1  continue straight into the next word after done.
- i_data  input  1  serial line; synchronous to clk, no internal synchroniser.
- o_data  output  DATA_BIT  last completed word.
- o_done_tick  output  1  one-clock pulse when o_data updates.
- o_busy  output  1  high in S_ALIGN, S_RECV and S_DONE.
- o_vote_err  output  1  word-level flag: some bit's three samples disagreed.

Behaviour:
- Reset: single clock domain; reset is asynchronous and active-low (rst_n). All state is cleared immediately, including mid-word.
  - state=S_IDLE, o_data=0, o_done_tick=0, o_busy=0, o_vote_err=0.
  - Counters cleared; count_max=LOW_FREQ-1.
- Registers:
  - count: 8-bit.
  - count_max: 8-bit, equal to period-1.
  - bit_idx: 6-bit.
  - shift buffer: DATA_BIT.
  - vote accumulator: 2-bit count of ones.
  - err_acc: 1 bit.
- S_IDLE:
  - On i_start: latch count_max from i_sel_freq, clear count/bit_idx/err_acc/shift buffer, then go to S_ALIGN.
  - i_stop is ignored while idle.
- S_ALIGN: exactly one cycle, then S_RECV with count=0.
  - This places the first bit window 2 clocks after the i_start edge, matching the transmitter's start-to-line latency.
- S_RECV (mid = count_max>>1):
  - Samples i_data when count == mid-1, mid and mid+1.
  - At mid+1, the bit is resolved as majority (ones>=2) and shifted in at the MSB (shift right), so after DATA_BIT bits bit 0 sits at o_data[0].
  - If the three samples are not all equal, err_acc is set.
  - When count == count_max: count resets to 0, and count_max for the next bit is reloaded from i_sel_freq as sampled in that cycle.
  - If bit_idx == DATA_BIT-1, go to S_DONE; otherwise bit_idx increments.
  - Otherwise count increments.
- S_DONE, one cycle:
  - o_data <= shift buffer, o_vote_err <= err_acc, o_done_tick=1.
  - If i_repeat=1: clear bit_idx/err_acc, reload count_max from i_sel_freq, go to S_ALIGN.
  - Else go to S_IDLE.
- o_done_tick is registered and asserted in the cycle after S_DONE is entered; it lasts exactly 1 clock.
- i_stop in S_ALIGN, S_RECV or S_DONE: go to S_IDLE next cycle.
  - o_data, o_vote_err and o_done_tick are not updated.
  - The partial word is discarded.
  - i_stop has priority over bit completion, done and repeat.
- i_start while busy: ignored.
- Simultaneous i_start and i_stop in S_IDLE: start wins.
- o_data and o_vote_err hold their values until the next completed word.
- Period change mid-bit has no effect. i_sel_freq is sampled only at start, at bit end, and at repeat.
- Latency: o_done_tick asserts 2 + sum(bit periods) + 1 clocks after the i_start edge.

Test Plan:
- DATA_BIT=16, LOW=20, HIGH=10. Drive 0xA5C3 at LOW on all bits, i_start at cycle 0 → o_data=0xA5C3, o_vote_err=0, a single o_done_tick at cycle 323, o_busy low afterwards.
- i_sel_freq=1 for bits 0-7 and 0 for bits 8-15, with data 0x00FF → o_data=0x00FF and o_done_tick at cycle 243.
- 0x1234 at LOW with a 1-cycle glitch at sample point mid of bit 3 → o_data=0x1234 and o_vote_err=1. A following clean word → o_vote_err=0.
- i_repeat=1 with words 0x1111 then 0x2222, LOW → two o_done_ticks 322 cycles apart and o_data updates in sequence. Dropping i_repeat → return to idle.
- i_stop at bit 7 of word 0xFFFF, after a prior word 0x0F0F → no done tick, o_data stays 0x0F0F, and state is idle on the next cycle.
- Pull rst_n low mid-word for 1 cycle → all outputs 0 immediately. A subsequent i_start receives 0xBEEF correctly.
